// File: rtl/prism_load_pkg.sv
// Shared types for the PRISM load sequencer: FSM state encoding and the buffered
// config word carried through the load FIFO.
package prism_load_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RUN     = 3'd5,
        ST_HALTED  = 3'd6
    } state_e;

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cfg_word_t;

endpackage

// File: rtl/prism_load_fifo.sv
// Synchronous FIFO of config words with a registered occupancy count.
// flush_i empties the buffer and takes precedence over a same-cycle push.
module prism_load_fifo
    import prism_load_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  cfg_word_t                  wdata_i,
    output cfg_word_t                  rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    cfg_word_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot a full-buffer push lands in.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/prism_load_sequencer.sv
// Loads a PRISM program through the debug port, then sequences reset release, enable,
// run and halt. Build macro PRISM_LOAD_VERIFY_EN adds a read-back check after each word.
module prism_load_sequencer
    import prism_load_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int RST_CYCLES   = 4,
    parameter int AUTO_RESTART = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_last,
    input  logic              start,
    input  logic              restart_req,
    input  logic              abort,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_wr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              prism_debug_reset,
    output logic              prism_fsm_enable,
    output logic [ADDR_W-1:0] prism_debug_addr,
    output logic              prism_debug_wr,
    output logic [DATA_W-1:0] prism_debug_wdata,
    input  logic [DATA_W-1:0] prism_debug_rdata,
    input  logic              prism_halt,
    output logic              busy,
    output logic [2:0]        state_o,
    output logic              event_o,
    output logic              err_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e           state_q, state_d;
    logic [7:0]       rst_cnt_q, rst_cnt_d;
    logic             dbg_rst_q, dbg_rst_d;
    logic             en_q, en_d;
    logic             event_q, event_d;
    logic             err_q, err_d;
    logic             halt_prev_q;
    logic             fifo_full, fifo_empty, pop;
    logic             start_ok, err_set;
    logic [CNT_W-1:0] fifo_count_unused;
    cfg_word_t        head, push_word;
`ifdef PRISM_LOAD_VERIFY_EN
    logic             vphase_q, vphase_d;
    cfg_word_t        ver_q, ver_d;
`else
    logic             rdata_unused;
    assign rdata_unused = ^prism_debug_rdata;
`endif

    assign busy      = !(state_q == ST_IDLE || state_q == ST_HALTED);
    assign pop       = (state_q == ST_LOAD) && !fifo_empty;
    assign cfg_ready = !fifo_full || pop;
    assign host_gnt  = host_wr && !busy && !start;
    assign start_ok  = start && !busy;
    assign err_set   = busy && (start || host_wr);
    assign push_word = {cfg_last, cfg_addr, cfg_data};

    prism_load_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (abort),
        .push_i  (cfg_valid && cfg_ready),
        .pop_i   (pop),
        .wdata_i (push_word),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    // Host and load engine never collide: grants only happen outside busy states.
    always_comb begin
        prism_debug_addr  = '0;
        prism_debug_wr    = 1'b0;
        prism_debug_wdata = '0;
        if (host_gnt) begin
            prism_debug_addr  = host_addr;
            prism_debug_wr    = 1'b1;
            prism_debug_wdata = host_wdata;
        end else if (pop) begin
            prism_debug_addr  = head.addr;
            prism_debug_wr    = 1'b1;
            prism_debug_wdata = head.data;
        end
`ifdef PRISM_LOAD_VERIFY_EN
        else if (state_q == ST_VERIFY) begin
            prism_debug_addr = ver_q.addr;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        dbg_rst_d = dbg_rst_q;
        en_d      = en_q;
        event_d   = 1'b0;
        err_d     = err_q;
`ifdef PRISM_LOAD_VERIFY_EN
        vphase_d  = vphase_q;
        ver_d     = ver_q;
`endif
        if (abort) begin
            state_d   = ST_IDLE;
            dbg_rst_d = 1'b0;
            en_d      = 1'b0;
            err_d     = 1'b0;
        end else if (start_ok) begin
            state_d   = ST_RESET;
            rst_cnt_d = 8'(RST_CYCLES - 1);
            dbg_rst_d = 1'b1;
            en_d      = 1'b0;
            err_d     = 1'b0;
        end else begin
            if (err_set) err_d = 1'b1;
            case (state_q)
                ST_RESET: begin
                    if (rst_cnt_q == 8'd0) state_d = ST_LOAD;
                    else                   rst_cnt_d = rst_cnt_q - 8'd1;
                end
                ST_LOAD: begin
                    if (pop) begin
`ifdef PRISM_LOAD_VERIFY_EN
                        state_d  = ST_VERIFY;
                        vphase_d = 1'b0;
                        ver_d    = head;
`else
                        if (head.last) begin
                            state_d   = ST_RELEASE;
                            dbg_rst_d = 1'b0;
                            event_d   = 1'b1;
                        end
`endif
                    end
                end
`ifdef PRISM_LOAD_VERIFY_EN
                ST_VERIFY: begin
                    // Phase 0 presents the address; read data is valid in phase 1.
                    if (!vphase_q) begin
                        vphase_d = 1'b1;
                    end else if (prism_debug_rdata != ver_q.data) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else if (ver_q.last) begin
                        state_d   = ST_RELEASE;
                        dbg_rst_d = 1'b0;
                        event_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
`endif
                ST_RELEASE: begin
                    state_d = ST_RUN;
                    en_d    = 1'b1;
                end
                ST_RUN: begin
                    if (prism_halt && !halt_prev_q) begin
                        state_d = ST_HALTED;
                        event_d = 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (restart_req && (AUTO_RESTART != 0)) state_d = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    // halt_prev_q samples every cycle, so a halt already high on RUN entry is no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            dbg_rst_q   <= 1'b0;
            en_q        <= 1'b0;
            event_q     <= 1'b0;
            err_q       <= 1'b0;
            halt_prev_q <= 1'b0;
`ifdef PRISM_LOAD_VERIFY_EN
            vphase_q    <= 1'b0;
            ver_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            dbg_rst_q   <= dbg_rst_d;
            en_q        <= en_d;
            event_q     <= event_d;
            err_q       <= err_d;
            halt_prev_q <= prism_halt;
`ifdef PRISM_LOAD_VERIFY_EN
            vphase_q    <= vphase_d;
            ver_q       <= ver_d;
`endif
        end
    end

    assign prism_debug_reset = dbg_rst_q;
    assign prism_fsm_enable  = en_q;
    assign event_o           = event_q;
    assign err_o             = err_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_prism_load_sequencer.sv
// Bench for prism_load_sequencer: directed sequences, a host-arbitration vector table,
// and randomized programs checked against a queue-based model of the debug writes.
module tb_prism_load_sequencer;

    logic        clk, rst;
    logic        cfg_valid, cfg_ready, cfg_last;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        start, restart_req, abort;
    logic [5:0]  host_addr;
    logic        host_wr, host_gnt;
    logic [31:0] host_wdata;
    logic        prism_debug_reset, prism_fsm_enable, prism_debug_wr;
    logic [5:0]  prism_debug_addr;
    logic [31:0] prism_debug_wdata, prism_debug_rdata;
    logic        prism_halt, busy, event_o, err_o;
    logic [2:0]  state_o;

    prism_load_sequencer #(.FIFO_DEPTH(4), .RST_CYCLES(4), .AUTO_RESTART(1)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_last(cfg_last),
        .start(start), .restart_req(restart_req), .abort(abort),
        .host_addr(host_addr), .host_wr(host_wr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .prism_debug_reset(prism_debug_reset), .prism_fsm_enable(prism_fsm_enable),
        .prism_debug_addr(prism_debug_addr), .prism_debug_wr(prism_debug_wr),
        .prism_debug_wdata(prism_debug_wdata), .prism_debug_rdata(prism_debug_rdata),
        .prism_halt(prism_halt), .busy(busy), .state_o(state_o),
        .event_o(event_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple PRISM debug memory: reads return data one cycle after the address.
    logic [31:0] pmem [64];
    logic        corrupt_en;
    logic [5:0]  corrupt_addr;
    always @(posedge clk) begin
        prism_debug_rdata <= pmem[prism_debug_addr] ^
                             ((corrupt_en && prism_debug_addr == corrupt_addr) ? 32'h1 : 32'h0);
        if (prism_debug_wr) pmem[prism_debug_addr] <= prism_debug_wdata;
    end

    typedef struct packed { logic [5:0] a; logic [31:0] d; } tw_t;
    typedef struct {
        logic        wr, st, ab;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        gnt, ewr;
        logic [5:0]  eaddr;
        logic [31:0] edata;
    } host_vec_t;

    int        total = 0, bad = 0;
    tw_t       exp_q[$];
    tw_t       q[$];
    tw_t       w;
    host_vec_t hv[5];
    int        n, pushed, pre, k, d;
    bit        done, en_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [5:0] a, input logic [31:0] dd, input logic l);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = dd; cfg_last = l;
        cyc();
        cfg_valid = 1'b0; cfg_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; cyc(); abort = 1'b0;
    endtask

    task automatic wait_reset(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, " rst state"}, state_o, 3'd1);
            chk({tag, " rst dbgrst"}, prism_debug_reset, 1'b1);
            chk({tag, " rst en"}, prism_fsm_enable, 1'b0);
            cyc();
        end
    endtask

    // Consume exp_q: each word must appear as a debug write, then RELEASE and RUN.
    task automatic expect_load(input string tag);
        tw_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " load state"}, state_o, 3'd2);
            chk({tag, " wr"}, prism_debug_wr, 1'b1);
            chk({tag, " addr"}, prism_debug_addr, e.a);
            chk({tag, " wdata"}, prism_debug_wdata, e.d);
            chk({tag, " load dbgrst"}, prism_debug_reset, 1'b1);
            cyc();
            cfg_valid = 1'b0;
`ifdef PRISM_LOAD_VERIFY_EN
            chk({tag, " vfy state"}, state_o, 3'd3);
            chk({tag, " vfy wr"}, prism_debug_wr, 1'b0);
            chk({tag, " vfy addr"}, prism_debug_addr, e.a);
            cyc();
            cyc();
`endif
        end
        chk({tag, " release state"}, state_o, 3'd4);
        chk({tag, " release event"}, event_o, 1'b1);
        chk({tag, " release dbgrst"}, prism_debug_reset, 1'b0);
        chk({tag, " release en"}, prism_fsm_enable, 1'b0);
        cyc();
        chk({tag, " run state"}, state_o, 3'd5);
        chk({tag, " run en"}, prism_fsm_enable, 1'b1);
        chk({tag, " run event"}, event_o, 1'b0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) pmem[i] = 32'h0;
        corrupt_en = 1'b0; corrupt_addr = 6'h0;
        cfg_valid = 0; cfg_addr = 0; cfg_data = 0; cfg_last = 0;
        start = 0; restart_req = 0; abort = 0;
        host_addr = 0; host_wr = 0; host_wdata = 0; prism_halt = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset cfg_ready", cfg_ready, 1'b1);
        chk("reset state", state_o, 3'd0);
        chk("reset busy", busy, 1'b0);
        chk("reset err", err_o, 1'b0);
        chk("reset event", event_o, 1'b0);
        chk("reset dbgrst", prism_debug_reset, 1'b0);
        chk("reset en", prism_fsm_enable, 1'b0);
        chk("reset wr", prism_debug_wr, 1'b0);
        chk("reset addr", prism_debug_addr, 6'h0);
        chk("reset gnt", host_gnt, 1'b0);
        rst = 1'b0;
        cyc();

        // Preloaded 3-word program
        push(6'h04, 32'h11111111, 1'b0);
        push(6'h08, 32'h22222222, 1'b0);
        push(6'h0C, 32'h33333333, 1'b1);
        pulse_start();
        wait_reset("pre");
        exp_q = '{'{6'h04, 32'h11111111}, '{6'h08, 32'h22222222}, '{6'h0C, 32'h33333333}};
        expect_load("pre");

        // Start while busy is ignored and flags an error
        pulse_start();
        chk("busy start state", state_o, 3'd5);
        chk("busy start err", err_o, 1'b1);

        // Halt edge, auto restart, halt already high on re-entry
        prism_halt = 1'b1; cyc();
        chk("halt state", state_o, 3'd6);
        chk("halt event", event_o, 1'b1);
        chk("halt en", prism_fsm_enable, 1'b1);
        cyc();
        chk("halt event one-shot", event_o, 1'b0);
        restart_req = 1'b1; cyc(); restart_req = 1'b0;
        chk("restart state", state_o, 3'd5);
        chk("restart en", prism_fsm_enable, 1'b1);
        cyc(); cyc();
        chk("held halt no edge", state_o, 3'd5);
        prism_halt = 1'b0; cyc();
        prism_halt = 1'b1; cyc();
        chk("rearm halt state", state_o, 3'd6);
        chk("rearm halt event", event_o, 1'b1);
        prism_halt = 1'b0;
        pulse_start();
        chk("halted start state", state_o, 3'd1);
        chk("halted start clears err", err_o, 1'b0);
        chk("halted start en", prism_fsm_enable, 1'b0);
        do_abort();
        chk("abort state", state_o, 3'd0);
        chk("abort en", prism_fsm_enable, 1'b0);
        chk("abort dbgrst", prism_debug_reset, 1'b0);

        // Host arbitration vectors applied in IDLE
        hv[0] = '{1'b1, 1'b0, 1'b0, 6'h15, 32'hDEADBEEF, 1'b1, 1'b1, 6'h15, 32'hDEADBEEF};
        hv[1] = '{1'b0, 1'b0, 1'b0, 6'h2A, 32'h12345678, 1'b0, 1'b0, 6'h00, 32'h00000000};
        hv[2] = '{1'b1, 1'b1, 1'b1, 6'h3F, 32'hFFFFFFFF, 1'b0, 1'b0, 6'h00, 32'h00000000};
        hv[3] = '{1'b1, 1'b0, 1'b0, 6'h3F, 32'h00000000, 1'b1, 1'b1, 6'h3F, 32'h00000000};
        hv[4] = '{1'b1, 1'b0, 1'b1, 6'h01, 32'hA5A5A5A5, 1'b1, 1'b1, 6'h01, 32'hA5A5A5A5};
        for (int i = 0; i < 5; i++) begin
            host_wr = hv[i].wr; start = hv[i].st; abort = hv[i].ab;
            host_addr = hv[i].addr; host_wdata = hv[i].data;
            #1;
            chk($sformatf("hv%0d gnt", i), host_gnt, hv[i].gnt);
            chk($sformatf("hv%0d wr", i), prism_debug_wr, hv[i].ewr);
            chk($sformatf("hv%0d addr", i), prism_debug_addr, hv[i].eaddr);
            chk($sformatf("hv%0d wdata", i), prism_debug_wdata, hv[i].edata);
            cyc();
            host_wr = 0; start = 0; abort = 0;
            chk($sformatf("hv%0d state", i), state_o, 3'd0);
            chk($sformatf("hv%0d err", i), err_o, 1'b0);
        end

        // Host write while LOAD waits on an empty FIFO
        pulse_start();
        wait_reset("host");
        host_wr = 1'b1; host_addr = 6'h2A; host_wdata = 32'hCAFEF00D;
        #1;
        chk("load host gnt", host_gnt, 1'b0);
        chk("load host wr", prism_debug_wr, 1'b0);
        chk("load host wdata", prism_debug_wdata, 32'h0);
        cyc();
        host_wr = 1'b0;
        chk("load host err", err_o, 1'b1);
        chk("load host state", state_o, 3'd2);
        push(6'h30, 32'h44444444, 1'b1);
        exp_q = '{'{6'h30, 32'h44444444}};
        expect_load("host");
        chk("err sticky", err_o, 1'b1);
        do_abort();
        chk("abort clears err", err_o, 1'b0);

        // Overfill the FIFO while idle; held word enters on the first pop
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill ready %0d", i), cfg_ready, 1'b1);
            push(6'(8 + i), 32'hA0000000 + 32'(i), 1'b0);
        end
        chk("full ready", cfg_ready, 1'b0);
        cfg_valid = 1'b1; cfg_addr = 6'h20; cfg_data = 32'hB5B5B5B5; cfg_last = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("held ready", cfg_ready, 1'b0);
            cyc();
        end
        chk("pop ready", cfg_ready, 1'b1);
        exp_q = '{'{6'h08, 32'hA0000000}, '{6'h09, 32'hA0000001}, '{6'h0A, 32'hA0000002},
                  '{6'h0B, 32'hA0000003}, '{6'h20, 32'hB5B5B5B5}};
        expect_load("full");
        cfg_last = 1'b0;
        do_abort();

        // Abort during the first of three loaded words
        push(6'h04, 32'h11111111, 1'b0);
        push(6'h08, 32'h22222222, 1'b0);
        push(6'h0C, 32'h33333333, 1'b1);
        pulse_start();
        wait_reset("abt");
        chk("abt first wr", prism_debug_wr, 1'b1);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abt state", state_o, 3'd0);
        chk("abt en", prism_fsm_enable, 1'b0);
        chk("abt dbgrst", prism_debug_reset, 1'b0);
        chk("abt ready", cfg_ready, 1'b1);
        chk("abt wr", prism_debug_wr, 1'b0);
        for (int i = 0; i < 3; i++) push(6'h01, 32'h1, 1'b0);
        chk("abt flushed 3 pushed", cfg_ready, 1'b1);
        push(6'h01, 32'h1, 1'b0);
        chk("abt flushed 4 pushed", cfg_ready, 1'b0);
        do_abort();

        // Asynchronous reset in the middle of a load
        push(6'h05, 32'h55555555, 1'b0);
        push(6'h06, 32'h66666666, 1'b1);
        pulse_start();
        wait_reset("arst");
        #2 rst = 1'b1;
        #1;
        chk("arst state", state_o, 3'd0);
        chk("arst dbgrst", prism_debug_reset, 1'b0);
        chk("arst ready", cfg_ready, 1'b1);
        chk("arst wr", prism_debug_wr, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        repeat (4) cyc();
        chk("arst fifo empty", prism_debug_wr, 1'b0);
        do_abort();

`ifdef PRISM_LOAD_VERIFY_EN
        // Read-back mismatch on the second word
        push(6'h04, 32'h11111111, 1'b0);
        push(6'h08, 32'h22222222, 1'b0);
        push(6'h0C, 32'h33333333, 1'b1);
        corrupt_en = 1'b1; corrupt_addr = 6'h08;
        pulse_start();
        en_seen = 1'b0;
        for (int i = 0; i < 40 && state_o != 3'd0; i++) begin
            if (prism_fsm_enable) en_seen = 1'b1;
            cyc();
        end
        chk("vfy fail state", state_o, 3'd0);
        chk("vfy fail err", err_o, 1'b1);
        chk("vfy fail dbgrst", prism_debug_reset, 1'b1);
        chk("vfy fail en never", en_seen, 1'b0);
        corrupt_en = 1'b0;
        do_abort();
`endif

        // Randomized programs with concurrent feeding
        for (int it = 0; it < 25; it++) begin
            do_abort();
            q.delete();
            n = $urandom_range(1, 6);
            pushed = 0;
            pre = $urandom_range(0, (n < 4) ? n : 4);
            for (int i = 0; i < pre; i++) begin
                w.a = 6'($urandom); w.d = $urandom;
                push(w.a, w.d, pushed == n - 1);
                q.push_back(w);
                pushed++;
            end
            pulse_start();
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                if (prism_debug_wr) begin
                    chk("rnd wr state", state_o, 3'd2);
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rnd unexpected write: addr 0x%0h, none pending", prism_debug_addr);
                    end else begin
                        w = q.pop_front();
                        chk("rnd addr", prism_debug_addr, w.a);
                        chk("rnd wdata", prism_debug_wdata, w.d);
                        if (q.size() == 0 && pushed == n) done = 1'b1;
                    end
                end
                if (!done && pushed < n && $urandom_range(0, 1) == 1) begin
                    w.a = 6'($urandom); w.d = $urandom;
                    cfg_valid = 1'b1; cfg_addr = w.a; cfg_data = w.d; cfg_last = (pushed == n - 1);
                    if (cfg_ready) begin
                        q.push_back(w);
                        pushed++;
                    end
                end else begin
                    cfg_valid = 1'b0;
                end
                cyc();
            end
            cfg_valid = 1'b0; cfg_last = 1'b0;
            chk("rnd program done", done, 1'b1);
            k = 0;
            while (!event_o && k < 5) begin cyc(); k++; end
            chk("rnd release state", state_o, 3'd4);
            chk("rnd release event", event_o, 1'b1);
            cyc();
            chk("rnd run en", prism_fsm_enable, 1'b1);
            d = $urandom_range(0, 5);
            for (int i = 0; i < d; i++) begin
                chk("rnd run hold", state_o, 3'd5);
                cyc();
            end
            prism_halt = 1'b1; cyc();
            chk("rnd halt state", state_o, 3'd6);
            chk("rnd halt event", event_o, 1'b1);
            prism_halt = 1'b0;
        end
        do_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
